// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR block: addresses, op encoding,
// controller states and the address-decode helper.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    typedef enum logic [1:0] {
        CSR_OP_WRITE = 2'd0,
        CSR_OP_SET   = 2'd1,
        CSR_OP_CLEAR = 2'd2,
        CSR_OP_NONE  = 2'd3
    } csr_op_e;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } csr_state_e;

    function automatic logic csr_legal(input logic [11:0] adr);
        case (adr)
            CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH:
                csr_legal = 1'b1;
            default:
                csr_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/csr_ctrl_if.sv
// Bundle between the pipeline (master) and the CSR controller (slave).
interface csr_ctrl_if;
    logic        csr_en;
    logic [11:0] csr_adr;
    logic [1:0]  csr_op_ctr;
    logic        csr_imm_en;
    logic        csr_read_en;
    logic        csr_wr_en;
    logic [31:0] rs1_data;
    logic [4:0]  zimm;
    logic        inst_retire;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        mret;
    logic        redirect_ack;
    logic [31:0] csr_rdata;
    logic        illegal_csr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    modport master (
        output csr_en, csr_adr, csr_op_ctr, csr_imm_en, csr_read_en, csr_wr_en,
               rs1_data, zimm, inst_retire, trap_req, trap_cause, trap_pc,
               mret, redirect_ack,
        input  csr_rdata, illegal_csr, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  csr_en, csr_adr, csr_op_ctr, csr_imm_en, csr_read_en, csr_wr_en,
               rs1_data, zimm, inst_retire, trap_req, trap_cause, trap_pc,
               mret, redirect_ack,
        output csr_rdata, illegal_csr, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter whose halves can be overwritten by software;
// a half write takes the cycle and the other half holds.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wr_lo) begin
            count[31:0] <= wdata;
        end else if (wr_hi) begin
            count[63:32] <= wdata;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_ctrl.sv
// Machine-mode CSR file with trap entry / MRET handling and a fetch redirect
// handshake that stalls the controller until the front end accepts it.
module csr_ctrl
    import csr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    csr_ctrl_if.slave  bus
);

    csr_state_e  state;
    logic        mie;
    logic        mpie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] redirect_pc;
    logic        redirect_valid;
    logic        busy;
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic        legal;
    logic        wr_fire;
    logic [31:0] old_val;
    logic [31:0] src;
    logic [31:0] new_val;

    assign legal = csr_legal(bus.csr_adr);

    always_comb begin
        old_val = '0;
        case (bus.csr_adr)
            CSR_MSTATUS:   old_val = {24'd0, mpie, 3'd0, mie, 3'd0};
            CSR_MTVEC:     old_val = mtvec;
            CSR_MSCRATCH:  old_val = mscratch;
            CSR_MEPC:      old_val = mepc;
            CSR_MCAUSE:    old_val = mcause;
            CSR_MCYCLE:    old_val = mcycle[31:0];
            CSR_MCYCLEH:   old_val = mcycle[63:32];
            CSR_MINSTRET:  old_val = minstret[31:0];
            CSR_MINSTRETH: old_val = minstret[63:32];
            default:       old_val = '0;
        endcase
    end

    assign src = bus.csr_imm_en ? {27'd0, bus.zimm} : bus.rs1_data;

    always_comb begin
        new_val = old_val;
        case (csr_op_e'(bus.csr_op_ctr))
            CSR_OP_WRITE: new_val = src;
            CSR_OP_SET:   new_val = old_val | src;
            CSR_OP_CLEAR: new_val = old_val & ~src;
            default:      new_val = old_val;
        endcase
    end

    // Trap and MRET own the cycle, so a coincident software write is dropped.
    assign wr_fire = bus.csr_en & bus.csr_wr_en & legal & (state == ST_RUN)
                   & ~bus.trap_req & ~bus.mret
                   & (bus.csr_op_ctr != CSR_OP_NONE);

    assign bus.csr_rdata      = (bus.csr_en & bus.csr_read_en & legal) ? old_val : '0;
    assign bus.illegal_csr    = bus.csr_en & ~legal;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc;
    assign bus.busy           = busy;

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .wr_lo (wr_fire && (bus.csr_adr == CSR_MCYCLE)),
        .wr_hi (wr_fire && (bus.csr_adr == CSR_MCYCLEH)),
        .wdata (new_val),
        .count (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.inst_retire),
        .wr_lo (wr_fire && (bus.csr_adr == CSR_MINSTRET)),
        .wr_hi (wr_fire && (bus.csr_adr == CSR_MINSTRETH)),
        .wdata (new_val),
        .count (minstret)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_RUN;
            mie            <= 1'b0;
            mpie           <= 1'b0;
            mtvec          <= '0;
            mscratch       <= '0;
            mepc           <= '0;
            mcause         <= '0;
            redirect_pc    <= '0;
            redirect_valid <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.trap_req) begin
                        mepc           <= bus.trap_pc;
                        mcause         <= bus.trap_cause;
                        mpie           <= mie;
                        mie            <= 1'b0;
                        redirect_pc    <= mtvec;
                        redirect_valid <= 1'b1;
                        busy           <= 1'b1;
                        state          <= ST_REDIRECT;
                    end else if (bus.mret) begin
                        mie            <= mpie;
                        mpie           <= 1'b1;
                        redirect_pc    <= mepc;
                        redirect_valid <= 1'b1;
                        busy           <= 1'b1;
                        state          <= ST_REDIRECT;
                    end else if (wr_fire) begin
                        case (bus.csr_adr)
                            CSR_MSTATUS: begin
                                mie  <= new_val[3];
                                mpie <= new_val[7];
                            end
                            CSR_MTVEC:    mtvec    <= {new_val[31:2], 2'b00};
                            CSR_MSCRATCH: mscratch <= new_val;
                            CSR_MEPC:     mepc     <= {new_val[31:2], 2'b00};
                            CSR_MCAUSE:   mcause   <= new_val;
                            default: ;
                        endcase
                    end
                end
                ST_REDIRECT: begin
                    if (bus.redirect_ack) begin
                        redirect_valid <= 1'b0;
                        busy           <= 1'b0;
                        state          <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_ctrl.sv
// Directed bench for csr_ctrl: expected values are queued when a step is
// driven and popped when the matching DUT output is sampled.
module tb_csr_ctrl;
    import csr_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cmp_cnt;
    int   fail_cnt;
    exp_t exp_q[$];

    csr_ctrl_if bus ();

    csr_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input logic [31:0] observed);
        exp_t e;
        cmp_cnt++;
        if (exp_q.size() == 0) begin
            fail_cnt++;
            $error("[TB] FAIL scoreboard_empty observed=%h expected=none", observed);
        end else begin
            e = exp_q.pop_front();
            assert (observed === e.val) else begin
                fail_cnt++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.val);
            end
        end
    endtask

    task automatic clear_csr_inputs();
        bus.csr_en      = 1'b0;
        bus.csr_adr     = '0;
        bus.csr_op_ctr  = CSR_OP_NONE;
        bus.csr_imm_en  = 1'b0;
        bus.csr_read_en = 1'b0;
        bus.csr_wr_en   = 1'b0;
        bus.rs1_data    = '0;
        bus.zimm        = '0;
    endtask

    task automatic idle_inputs();
        clear_csr_inputs();
        bus.inst_retire  = 1'b0;
        bus.trap_req     = 1'b0;
        bus.trap_cause   = '0;
        bus.trap_pc      = '0;
        bus.mret         = 1'b0;
        bus.redirect_ack = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [11:0] adr, input logic [1:0] op,
                                  input logic imm, input logic [31:0] rs1,
                                  input logic [4:0] z, input logic rd, input logic wr);
        bus.csr_en      = 1'b1;
        bus.csr_adr     = adr;
        bus.csr_op_ctr  = op;
        bus.csr_imm_en  = imm;
        bus.rs1_data    = rs1;
        bus.zimm        = z;
        bus.csr_read_en = rd;
        bus.csr_wr_en   = wr;
    endtask

    task automatic write_csr(input logic [11:0] adr, input logic [31:0] val);
        apply_stimulus(adr, CSR_OP_WRITE, 1'b0, val, 5'd0, 1'b0, 1'b1);
        step();
        clear_csr_inputs();
    endtask

    task automatic read_csr(input logic [11:0] adr, input logic [31:0] val, input string tag);
        apply_stimulus(adr, CSR_OP_NONE, 1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
        push_exp(tag, val);
        #1;
        check_output(bus.csr_rdata);
        clear_csr_inputs();
    endtask

    task automatic check_redirect(input logic valid, input logic bsy,
                                  input logic [31:0] pc, input string tag);
        push_exp({tag, "_valid"}, {31'd0, valid});
        check_output({31'd0, bus.redirect_valid});
        push_exp({tag, "_busy"}, {31'd0, bsy});
        check_output({31'd0, bus.busy});
        push_exp({tag, "_pc"}, pc);
        check_output(bus.redirect_pc);
    endtask

    initial begin
        cmp_cnt  = 0;
        fail_cnt = 0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        check_redirect(1'b0, 1'b0, 32'd0, "reset");
        read_csr(CSR_MSCRATCH, 32'd0, "reset_mscratch");
        read_csr(CSR_MCYCLE, 32'd0, "reset_mcycle");
        rst_n = 1'b1;
        step();

        // Set returns the old value in the same cycle and ORs in rs1.
        write_csr(CSR_MSCRATCH, 32'h0000_00F0);
        read_csr(CSR_MSCRATCH, 32'h0000_00F0, "mscratch_write");
        apply_stimulus(CSR_MSCRATCH, CSR_OP_SET, 1'b0, 32'h0F, 5'd0, 1'b1, 1'b1);
        push_exp("set_old_rdata", 32'h0000_00F0);
        #1;
        check_output(bus.csr_rdata);
        step();
        clear_csr_inputs();
        read_csr(CSR_MSCRATCH, 32'h0000_00FF, "set_result");

        // Immediate clear of MIE; rs1 of zero would leave MIE set if misrouted.
        write_csr(CSR_MSTATUS, 32'h8);
        read_csr(CSR_MSTATUS, 32'h8, "mstatus_mie");
        apply_stimulus(CSR_MSTATUS, CSR_OP_CLEAR, 1'b1, 32'd0, 5'd8, 1'b1, 1'b1);
        push_exp("clear_old_rdata", 32'h8);
        #1;
        check_output(bus.csr_rdata);
        step();
        clear_csr_inputs();
        read_csr(CSR_MSTATUS, 32'h0, "clear_mie");

        write_csr(CSR_MSTATUS, 32'hFFFF_FFFF);
        read_csr(CSR_MSTATUS, 32'h88, "mstatus_mask");
        write_csr(CSR_MTVEC, 32'h207);
        read_csr(CSR_MTVEC, 32'h204, "mtvec_align");
        write_csr(CSR_MEPC, 32'h103);
        read_csr(CSR_MEPC, 32'h100, "mepc_align");
        write_csr(CSR_MCAUSE, 32'h5);
        read_csr(CSR_MCAUSE, 32'h5, "mcause_write");
        write_csr(CSR_MSTATUS, 32'h8);

        apply_stimulus(CSR_MSCRATCH, CSR_OP_WRITE, 1'b0, 32'h77, 5'd0, 1'b1, 1'b0);
        step();
        clear_csr_inputs();
        read_csr(CSR_MSCRATCH, 32'hFF, "wr_disabled");
        apply_stimulus(CSR_MSCRATCH, CSR_OP_NONE, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        #1;
        push_exp("rd_disabled", 32'd0);
        check_output(bus.csr_rdata);
        push_exp("legal_not_illegal", 32'd0);
        check_output({31'd0, bus.illegal_csr});
        clear_csr_inputs();

        apply_stimulus(12'h7C0, CSR_OP_WRITE, 1'b0, 32'hDEAD, 5'd0, 1'b1, 1'b1);
        #1;
        push_exp("illegal_flag", 32'd1);
        check_output({31'd0, bus.illegal_csr});
        push_exp("illegal_rdata", 32'd0);
        check_output(bus.csr_rdata);
        step();
        clear_csr_inputs();
        read_csr(CSR_MSCRATCH, 32'hFF, "illegal_no_write");
        read_csr(CSR_MSTATUS, 32'h8, "illegal_no_state");

        // Trap, MRET and a write in one cycle: only the trap lands.
        apply_stimulus(CSR_MSCRATCH, CSR_OP_WRITE, 1'b0, 32'h123, 5'd0, 1'b1, 1'b1);
        bus.trap_req   = 1'b1;
        bus.trap_pc    = 32'h100;
        bus.trap_cause = 32'hB;
        bus.mret       = 1'b1;
        step();
        idle_inputs();
        check_redirect(1'b1, 1'b1, 32'h204, "trap");
        read_csr(CSR_MEPC, 32'h100, "trap_mepc");
        read_csr(CSR_MCAUSE, 32'hB, "trap_mcause");
        read_csr(CSR_MSCRATCH, 32'hFF, "trap_drops_write");
        read_csr(CSR_MSTATUS, 32'h80, "trap_mstatus");

        apply_stimulus(CSR_MSCRATCH, CSR_OP_WRITE, 1'b0, 32'h55, 5'd0, 1'b0, 1'b1);
        bus.trap_req   = 1'b1;
        bus.trap_pc    = 32'h300;
        bus.trap_cause = 32'h2;
        step();
        idle_inputs();
        check_redirect(1'b1, 1'b1, 32'h204, "redirect_hold1");
        step();
        check_redirect(1'b1, 1'b1, 32'h204, "redirect_hold2");
        bus.redirect_ack = 1'b1;
        step();
        idle_inputs();
        check_redirect(1'b0, 1'b0, 32'h204, "redirect_ack");
        read_csr(CSR_MSCRATCH, 32'hFF, "redirect_ignores_write");
        read_csr(CSR_MEPC, 32'h100, "redirect_ignores_trap");

        bus.mret = 1'b1;
        step();
        idle_inputs();
        check_redirect(1'b1, 1'b1, 32'h100, "mret");
        read_csr(CSR_MSTATUS, 32'h88, "mret_mstatus");
        bus.redirect_ack = 1'b1;
        step();
        idle_inputs();
        check_redirect(1'b0, 1'b0, 32'h100, "mret_ack");

        // mcycle wrap, then a low-half write beating the increment.
        write_csr(CSR_MCYCLE, 32'hFFFF_FFFF);
        write_csr(CSR_MCYCLEH, 32'hFFFF_FFFF);
        read_csr(CSR_MCYCLE, 32'hFFFF_FFFF, "mcycle_lo_max");
        read_csr(CSR_MCYCLEH, 32'hFFFF_FFFF, "mcycle_hi_max");
        step();
        read_csr(CSR_MCYCLE, 32'd0, "mcycle_lo_wrap");
        read_csr(CSR_MCYCLEH, 32'd0, "mcycle_hi_wrap");
        write_csr(CSR_MCYCLE, 32'h5);
        read_csr(CSR_MCYCLE, 32'h5, "mcycle_write_wins");
        read_csr(CSR_MCYCLEH, 32'h0, "mcycle_hi_holds");
        step();
        read_csr(CSR_MCYCLE, 32'h6, "mcycle_resume");

        write_csr(CSR_MINSTRET, 32'hFFFF_FFFF);
        write_csr(CSR_MINSTRETH, 32'hFFFF_FFFF);
        read_csr(CSR_MINSTRETH, 32'hFFFF_FFFF, "minstret_hi_max");
        bus.inst_retire = 1'b1;
        step();
        read_csr(CSR_MINSTRET, 32'd0, "minstret_lo_wrap");
        read_csr(CSR_MINSTRETH, 32'd0, "minstret_hi_wrap");
        step();
        step();
        bus.inst_retire = 1'b0;
        step();
        read_csr(CSR_MINSTRET, 32'd2, "minstret_count");

        // Reset mid-redirect abandons the redirect with no ack.
        write_csr(CSR_MSCRATCH, 32'hAA);
        bus.trap_req = 1'b1;
        bus.trap_pc  = 32'h40;
        step();
        idle_inputs();
        check_redirect(1'b1, 1'b1, 32'h204, "pre_reset_redirect");
        #2;
        rst_n = 1'b0;
        #1;
        check_redirect(1'b0, 1'b0, 32'd0, "reset_in_redirect");
        read_csr(CSR_MSCRATCH, 32'd0, "reset_clears_mscratch");
        read_csr(CSR_MTVEC, 32'd0, "reset_clears_mtvec");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_redirect(1'b0, 1'b0, 32'd0, "post_reset_run");
        read_csr(CSR_MCYCLE, 32'd1, "post_reset_mcycle");

        if (exp_q.size() != 0) begin
            fail_cnt++;
            $display("[TB] FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
